// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/stall controller
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } hazard_state_e;

   localparam int LOAD_LAT_MAX = 7;
   localparam int BUB_CNT_W    = 3;

   // Extra bubbles still owed after the first one; out-of-range latencies are clamped to 1..7
   function automatic logic [BUB_CNT_W-1:0] lat_reload(input int lat);
      int clamped;
      clamped = (lat < 1) ? 1 : ((lat > LOAD_LAT_MAX) ? LOAD_LAT_MAX : lat);
      return BUB_CNT_W'(clamped - 1);
   endfunction

endpackage

// File: rtl/hazard_dep_check.sv
// rtl/hazard_dep_check.sv - load-use dependency compare between EX destination and ID sources
module hazard_dep_check
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  rs1_used_id,
   input  logic                  rs2_used_id,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic                  mem_read_ex,
   output logic                  lu
);

   // x0 is never a real producer, and unused source fields hold don't-care encodings
   always_comb begin
      lu = mem_read_ex && (rd_ex != '0) &&
           ((rs1_used_id && (rs1_id == rd_ex)) ||
            (rs2_used_id && (rs2_id == rd_ex)));
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard/stall controller; HAZARD_STALL_CNT_EN enables stall_cycles counter
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  rs1_used_id,
   input  logic                  rs2_used_id,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic                  mem_read_ex,
   input  logic                  dmem_req_mem,
   input  logic                  dmem_ready,
   input  logic                  branch_taken_ex,
   output logic                  pc_w,
   output logic                  pipeline_if_id_en,
   output logic                  pipeline_id_ex_en,
   output logic                  pipeline_ex_mem_en,
   output logic                  hazard_mux_sel,
   output logic                  flush_if_id,
   output logic [CNT_W-1:0]      stall_cycles
);

   localparam logic [BUB_CNT_W-1:0] LAT_RELOAD = lat_reload(LOAD_LAT);

   hazard_state_e         state_q, state_d, eff_state;
   logic [BUB_CNT_W-1:0]  bub_cnt_q, bub_cnt_d;
   logic                  lu;
   logic                  freeze;

   hazard_dep_check #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_dep_check (
      .rs1_id      (rs1_id),
      .rs2_id      (rs2_id),
      .rs1_used_id (rs1_used_id),
      .rs2_used_id (rs2_used_id),
      .rd_ex       (rd_ex),
      .mem_read_ex (mem_read_ex),
      .lu          (lu)
   );

   assign freeze = dmem_req_mem && !dmem_ready;

   // Next-state and output decode; a MEM_WAIT exit cycle behaves as the state it resolves to
   always_comb begin
      state_d            = state_q;
      bub_cnt_d          = bub_cnt_q;
      pc_w               = 1'b1;
      pipeline_if_id_en  = 1'b1;
      pipeline_id_ex_en  = 1'b1;
      pipeline_ex_mem_en = 1'b1;
      hazard_mux_sel     = 1'b0;
      flush_if_id        = 1'b0;
      eff_state          = state_q;
      if (state_q == MEM_WAIT) begin
         eff_state = (bub_cnt_q != '0) ? LU_STALL : RUN;
      end

      if (freeze) begin
         pc_w               = 1'b0;
         pipeline_if_id_en  = 1'b0;
         pipeline_id_ex_en  = 1'b0;
         pipeline_ex_mem_en = 1'b0;
         state_d            = MEM_WAIT;
      end else begin
         case (eff_state)
            LU_STALL: begin
               pc_w              = 1'b0;
               pipeline_if_id_en = 1'b0;
               hazard_mux_sel    = 1'b1;
               if (bub_cnt_q <= BUB_CNT_W'(1)) begin
                  bub_cnt_d = '0;
                  state_d   = RUN;
               end else begin
                  bub_cnt_d = bub_cnt_q - BUB_CNT_W'(1);
                  state_d   = LU_STALL;
               end
            end
            default: begin
               state_d = RUN;
               if (branch_taken_ex) begin
                  hazard_mux_sel = 1'b1;
                  flush_if_id    = 1'b1;
               end else if (lu) begin
                  pc_w              = 1'b0;
                  pipeline_if_id_en = 1'b0;
                  hazard_mux_sel    = 1'b1;
                  if (LOAD_LAT > 1) begin
                     bub_cnt_d = LAT_RELOAD;
                     state_d   = LU_STALL;
                  end
               end
            end
         endcase
      end
   end

   // State and bubble counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         bub_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         bub_cnt_q <= bub_cnt_d;
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles where the PC is held
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_w && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Stall counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl with LOAD_LAT 1 and 3
module tb_hazard_stall_ctrl;

   localparam logic [5:0] RUNV = 6'b111100;
   localparam logic [5:0] STL  = 6'b001110;
   localparam logic [5:0] FRZ  = 6'b000000;
   localparam logic [5:0] BRV  = 6'b111111;

   typedef struct {
      string       tag;
      logic [5:0]  e1;
      logic [5:0]  e3;
      logic [31:0] c1;
      logic [31:0] c3;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1_id, rs2_id, rd_ex;
   logic       rs1_used_id, rs2_used_id, mem_read_ex, dmem_req_mem, dmem_ready, branch_taken_ex;

   logic        pc_w1, ifid1, idex1, exmem1, mux1, flush1;
   logic [2:0]  cnt1;
   logic        pc_w3, ifid3, idex3, exmem3, mux3, flush3;
   logic [31:0] cnt3;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] ecnt1 = '0;
   logic [31:0] ecnt3 = '0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(3)) dut1 (
      .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .rd_ex(rd_ex),
      .mem_read_ex(mem_read_ex), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
      .branch_taken_ex(branch_taken_ex), .pc_w(pc_w1), .pipeline_if_id_en(ifid1),
      .pipeline_id_ex_en(idex1), .pipeline_ex_mem_en(exmem1), .hazard_mux_sel(mux1),
      .flush_if_id(flush1), .stall_cycles(cnt1)
   );

   hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(32)) dut3 (
      .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .rd_ex(rd_ex),
      .mem_read_ex(mem_read_ex), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
      .branch_taken_ex(branch_taken_ex), .pc_w(pc_w3), .pipeline_if_id_en(ifid3),
      .pipeline_id_ex_en(idex3), .pipeline_ex_mem_en(exmem3), .hazard_mux_sel(mux3),
      .flush_if_id(flush3), .stall_cycles(cnt3)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus after the edge and queue what both instances must show
   task automatic step(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                       input logic req, input logic rdy, input logic br, input logic rs,
                       input logic [5:0] e1, input logic [5:0] e3, input bit chk);
      exp_t e;
      @(posedge clk);
      #1;
      rs1_id = r1; rs2_id = r2; rs1_used_id = u1; rs2_used_id = u2;
      rd_ex = rd; mem_read_ex = mr; dmem_req_mem = req; dmem_ready = rdy;
      branch_taken_ex = br; rst = rs;
      if (chk) begin
         e.tag = tag; e.e1 = e1; e.e3 = e3; e.c1 = ecnt1; e.c3 = ecnt3;
         sb_q.push_back(e);
      end
`ifdef HAZARD_STALL_CNT_EN
      if (rs) begin
         ecnt1 = '0;
         ecnt3 = '0;
      end else begin
         if (!e1[5] && ecnt1 != 32'd7) ecnt1 = ecnt1 + 32'd1;
         if (!e3[5] && ecnt3 != 32'hFFFF_FFFF) ecnt3 = ecnt3 + 32'd1;
      end
`endif
   endtask

   task automatic idle(input string tag, input logic [5:0] e1, input logic [5:0] e3);
      step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e1, e3, 1'b1);
   endtask

   // Compare each queued expectation against the DUT outputs mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq({e.tag, "_lat1"}, {58'd0, pc_w1, ifid1, idex1, exmem1, mux1, flush1}, {58'd0, e.e1});
         check_eq({e.tag, "_lat3"}, {58'd0, pc_w3, ifid3, idex3, exmem3, mux3, flush3}, {58'd0, e.e3});
         check_eq({e.tag, "_cnt1"}, {61'd0, cnt1}, {32'd0, e.c1});
         check_eq({e.tag, "_cnt3"}, {32'd0, cnt3}, {32'd0, e.c3});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rs1_id = '0; rs2_id = '0; rd_ex = '0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
      mem_read_ex = 1'b0; dmem_req_mem = 1'b0; dmem_ready = 1'b1; branch_taken_ex = 1'b0;

      step("rst0",      5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, RUNV, RUNV, 0);
      step("rst_state", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, RUNV, RUNV, 1);
      idle("idle", RUNV, RUNV);
      step("lu_rs2",    5'd3, 5'd5, 1, 1, 5'd5, 1, 0, 1, 0, 0, STL, STL, 1);
      idle("lu_tail1", RUNV, STL);
      idle("lu_tail2", RUNV, STL);
      idle("post_lu", RUNV, RUNV);
      step("x0_load",   5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 1, 0, 0, RUNV, RUNV, 1);
      step("rs2_unused",5'd2, 5'd7, 1, 0, 5'd7, 1, 0, 1, 0, 0, RUNV, RUNV, 1);
      step("not_load",  5'd9, 5'd0, 1, 0, 5'd9, 0, 0, 1, 0, 0, RUNV, RUNV, 1);
      step("lu_rs1",    5'd9, 5'd9, 1, 0, 5'd9, 1, 0, 1, 0, 0, STL, STL, 1);
      for (int i = 0; i < 4; i++)
         step("freeze",  5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0, FRZ, FRZ, 1);
      step("mem_exit",  5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 0, RUNV, STL, 1);
      idle("bub_after", RUNV, STL);
      idle("run_after", RUNV, RUNV);
      for (int i = 0; i < 2; i++)
         step("br_frz",  5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 0, FRZ, FRZ, 1);
      step("br_ready",  5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, 0, BRV, BRV, 1);
      idle("br_once", RUNV, RUNV);
      step("br_vs_lu",  5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 1, 1, 0, BRV, BRV, 1);
      idle("idle2", RUNV, RUNV);
      step("lu_frz",    5'd4, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0, 0, FRZ, FRZ, 1);
      step("lu_aft_frz",5'd4, 5'd0, 1, 0, 5'd4, 1, 1, 1, 0, 0, STL, STL, 1);
      step("frz_pre_rst",5'd0,5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0, FRZ, FRZ, 1);
      step("rst_frz",   5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 1, FRZ, FRZ, 1);
      idle("post_rst", RUNV, RUNV);
      idle("post_rst2", RUNV, RUNV);

      @(negedge clk);
      #1;
      check_eq("drain", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
